// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage access unit: opcodes, access-type encoding, FSM states.
// Opcode decode and load/store classification helpers live here so top and lane logic agree.
package mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [2:0] {
        ACC_LB  = 3'b000,
        ACC_LBU = 3'b001,
        ACC_LH  = 3'b010,
        ACC_LHU = 3'b011,
        ACC_LW  = 3'b100,
        ACC_SB  = 3'b101,
        ACC_SH  = 3'b110,
        ACC_SW  = 3'b111
    } acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic is_mem;
        acc_t typ;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.is_mem = 1'b1;
        d.typ    = ACC_LW;
        case (op)
            OP_LB:   d.typ = ACC_LB;
            OP_LBU:  d.typ = ACC_LBU;
            OP_LH:   d.typ = ACC_LH;
            OP_LHU:  d.typ = ACC_LHU;
            OP_LW:   d.typ = ACC_LW;
            OP_SB:   d.typ = ACC_SB;
            OP_SH:   d.typ = ACC_SH;
            OP_SW:   d.typ = ACC_SW;
            default: d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    // Stores are the three codes with bit 2 set other than LW.
    function automatic logic is_store(input acc_t typ);
        return typ[2] & (typ[1] | typ[0]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, store replication, load extract/extend.
// The misalign flag port exists only when MEM_ALIGN_EXC_EN is defined.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  acc_t        typ,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic        misalign
`endif
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rdata >> {a, 3'b000};
    assign byte_v  = shifted[7:0];
    // Half selection looks at a[1] only, so an odd half address degrades to aligned.
    assign half_v  = a[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        bus_wdata = 32'h0;
        load_data = 32'h0;
        case (typ)
            ACC_LB: begin
                be        = 4'b0001 << a;
                load_data = {{24{byte_v[7]}}, byte_v};
            end
            ACC_LBU: begin
                be        = 4'b0001 << a;
                load_data = {24'h0, byte_v};
            end
            ACC_LH: begin
                be        = a[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{half_v[15]}}, half_v};
            end
            ACC_LHU: begin
                be        = a[1] ? 4'b1100 : 4'b0011;
                load_data = {16'h0, half_v};
            end
            ACC_LW: begin
                be        = 4'b1111;
                load_data = rdata;
            end
            ACC_SB: begin
                be        = 4'b0001 << a;
                bus_wdata = {4{wdata[7:0]}};
            end
            ACC_SH: begin
                be        = a[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata[15:0]}};
            end
            ACC_SW: begin
                be        = 4'b1111;
                bus_wdata = wdata;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

`ifdef MEM_ALIGN_EXC_EN
    always_comb begin
        misalign = 1'b0;
        case (typ)
            ACC_LH, ACC_LHU, ACC_SH: misalign = a[0];
            ACC_LW, ACC_SW:          misalign = |a;
            default:                 misalign = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus master with wait timeout and pipeline stall.
// Defining MEM_ALIGN_EXC_EN adds adel/ades outputs and skips the bus for misaligned accesses.
//
//  state | meaning
//  IDLE  | no access in flight; a valid mem op stalls and issues
//  REQ   | bus_req held until bus_ack or wait budget runs out
//  DONE  | one-cycle completion: done, rdata_m, bus_err/adel/ades
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir_m,
    input  logic              valid_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    output logic              stall_m,
    output logic              done,
    output logic [31:0]       rdata_m,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic              adel,
    output logic              ades
`endif
);

    localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);

    state_t            state, state_nx;
    dec_t              dec;
    logic              start;
    acc_t              type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        wait_cnt;
    acc_t              sel_type;
    logic [1:0]        sel_a;
    logic [3:0]        be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic              unused_ir;

    assign unused_ir = ^ir_m[25:0];
    assign dec       = decode_op(ir_m[31:26]);
    assign start     = valid_m & dec.is_mem;

    // Live inputs feed the lane logic in IDLE so misalignment is known before issue.
    assign sel_type = (state == IDLE) ? dec.typ      : type_q;
    assign sel_a    = (state == IDLE) ? addr_m[1:0]  : addr_q[1:0];

`ifdef MEM_ALIGN_EXC_EN
    logic misalign;
    logic exc_q;

    mem_lane_align u_align (
        .typ       (sel_type),
        .a         (sel_a),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (be),
        .bus_wdata (lane_wdata),
        .load_data (load_data),
        .misalign  (misalign)
    );
`else
    mem_lane_align u_align (
        .typ       (sel_type),
        .a         (sel_a),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (be),
        .bus_wdata (lane_wdata),
        .load_data (load_data)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            type_q   <= ACC_LB;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            wait_cnt <= 8'h0;
`ifdef MEM_ALIGN_EXC_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    type_q   <= dec.typ;
                    addr_q   <= addr_m;
                    wdata_q  <= wdata_m;
                    rdata_q  <= 32'h0;
                    err_q    <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
`ifdef MEM_ALIGN_EXC_EN
                    exc_q    <= misalign;
`endif
                end
                REQ: begin
                    // Ack on the last allowed cycle takes priority over the timeout.
                    if (bus_ack) begin
                        rdata_q <= is_store(type_q) ? 32'h0 : load_data;
                    end else if (wait_cnt == 8'h0) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt - 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        stall_m  = 1'b0;
        bus_req  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall_m  = 1'b1;
                    state_nx = REQ;
`ifdef MEM_ALIGN_EXC_EN
                    if (misalign) state_nx = DONE;
`endif
                end
            end
            REQ: begin
                stall_m = 1'b1;
                bus_req = 1'b1;
                if (bus_ack || wait_cnt == 8'h0) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus_we    = bus_req & is_store(type_q);
    assign bus_be    = bus_req ? be : 4'b0000;
    assign bus_addr  = bus_req ? addr_q[ADDR_W-1:2] : '0;
    assign bus_wdata = bus_req ? lane_wdata : 32'h0;
    assign rdata_m   = done ? rdata_q : 32'h0;
    assign bus_err   = done & err_q;

`ifdef MEM_ALIGN_EXC_EN
    assign adel = done & exc_q & ~is_store(type_q);
    assign ades = done & exc_q &  is_store(type_q);
`endif

endmodule
